hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 3-stage RISC-V core. It drives the stall, flush and forward-select inputs of the fetch/decode stages and of the decode->execute pipeline register.
- Observes decode-stage source addresses plus execute and writeback destination info.
- Resolves three things: load-use hazards (multi-cycle stall FSM), control redirects (flush) and operand forwarding selects.

Parameters:
- LOAD_LAT, 1, number of bubble cycles inserted on a load-use hazard (legal range 1..7).
- WB_MEM, 2'b01, wb_selE encoding meaning "writeback from data memory" (load).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- adr1D  input  5  rs1 address in decode
- adr2D  input  5  rs2 address in decode
- rdE  input  5  destination register in execute
- reg_writeE  input  1  execute instruction writes rd
- wb_selE  input  2  execute writeback select
- rdW  input  5  destination register in writeback
- reg_writeW  input  1  writeback instruction writes rd
- redirectE  input  1  taken branch/jump resolved in execute
- stallF  output  1  hold PC
- stallD  output  1  hold fetch->decode register
- flushD  output  1  zero fetch->decode register
- flushE  output  1  zero decode->execute register (bubble)
- fwd_a_selD  output  2  rs1 source: 00 regfile, 01 execute result, 10 writeback result
- fwd_b_selD  output  2  rs2 source, same encoding
- stall_cnt  output  32  (only with HAZARD_PERF_CNT_EN) total stall cycles
- flush_cnt  output  32  (only with HAZARD_PERF_CNT_EN) total redirect flushes

Behaviour:
- Only the FSM state and the counters are registered. All outputs are combinational from state and inputs, so they take effect in the same cycle as the hazard.
- While rst=1: all outputs are 0, state=IDLE, bubble counter=0, perf counters=0.
- Load-use detect (luse): reg_writeE && wb_selE==WB_MEM && rdE!=0 && (rdE==adr1D || rdE==adr2D).
- FSM states: IDLE, LSTALL.
- IDLE, luse=1, redirectE=0:
  - assert stallF=stallD=flushE=1 this cycle;
  - if LOAD_LAT>1: next state LSTALL, counter=LOAD_LAT-1;
  - else: stay in IDLE.
- LSTALL:
  - assert stallF=stallD=flushE=1 and decrement the counter each cycle;
  - when the counter reaches 1 in a cycle, that cycle is the last stall cycle and the next state is IDLE.
  - luse is ignored in LSTALL, since the bubble has already been placed in execute.
- Total bubble length is exactly LOAD_LAT cycles.
- Redirect: redirectE=1 in any state:
  - flushD=flushE=1 and stallF=stallD=0 this cycle;
  - next state IDLE and counter=0, which aborts any stall in progress;
  - redirect has priority over luse in the same cycle.
- Forwarding (fwd_a_selD, per source address adrX in decode):
  - 01 if reg_writeE && rdE!=0 && rdE==adrX && wb_selE!=WB_MEM;
  - else 10 if reg_writeW && rdW!=0 && rdW==adrX;
  - else 00.
  - Execute has priority over writeback. x0 never forwards.
- fwd_b_selD uses the same rules with adr2D.
- Forward selects are driven even during a stall. Consumers ignore them while stallD=1.
- Simultaneous load-use hits on rs1 and rs2 produce a single LOAD_LAT-cycle stall.
- Reset asserted mid-LSTALL: the next cycle is IDLE with all outputs 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cnt increments by 1 on every cycle stallF=1;
  - flush_cnt increments by 1 on every cycle redirectE=1;
  - both are 32-bit, wrap from 32'hFFFFFFFF to 0, and clear on rst.
- When not defined: both ports and their counters are absent, and behaviour is otherwise identical.

Test Plan:
- LOAD_LAT=1; load rdE=5, wb_selE=01, reg_writeE=1, adr1D=5 -> exactly 1 cycle with stallF=stallD=flushE=1, then all 0; fwd_a_selD=10 once rdW=5 and reg_writeW=1.
- LOAD_LAT=3; same load-use on adr2D=5 -> stall/flushE high for exactly 3 consecutive cycles, then IDLE.
- LOAD_LAT=3; redirectE=1 in the 2nd stall cycle -> that cycle flushD=flushE=1 and stallF=0; the following cycle has no stall.
- ALU op rdE=7 and rdW=7, both writing, adr1D=adr2D=7 -> fwd_a_selD=fwd_b_selD=01. Repeat with rdE=0 -> 10. Repeat with rdE=rdW=0, adr=0 -> 00.
- Simultaneous luse and redirectE -> flushD=flushE=1, stallF=0, and no stall on the next cycle.
- With HAZARD_PERF_CNT_EN: two LOAD_LAT=3 stalls and one redirect -> stall_cnt=6, flush_cnt=1; assert rst -> both 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/execute/writeback observations in,
// stall, flush and forward-select controls out.
interface hazard_ctrl_if;
    logic [4:0] adr1D;
    logic [4:0] adr2D;
    logic [4:0] rdE;
    logic       reg_writeE;
    logic [1:0] wb_selE;
    logic [4:0] rdW;
    logic       reg_writeW;
    logic       redirectE;
    logic       stallF;
    logic       stallD;
    logic       flushD;
    logic       flushE;
    logic [1:0] fwd_a_selD;
    logic [1:0] fwd_b_selD;

    modport master (
        output adr1D, adr2D, rdE, reg_writeE, wb_selE,
        output rdW, reg_writeW, redirectE,
        input  stallF, stallD, flushD, flushE,
        input  fwd_a_selD, fwd_b_selD
    );

    modport slave (
        input  adr1D, adr2D, rdE, reg_writeE, wb_selE,
        input  rdW, reg_writeW, redirectE,
        output stallF, stallD, flushD, flushE,
        output fwd_a_selD, fwd_b_selD
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall FSM, redirect flush and forwarding select for the 3-stage core.
// Optional stall/flush perf counters: define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 1,
    parameter logic [1:0]  WB_MEM   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    typedef enum logic {IDLE, LSTALL} state_t;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       luse;
    logic       stall;
    logic       redir;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] adr,
        input logic [4:0] rd_e,
        input logic       we_e,
        input logic [1:0] sel_e,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_e && rd_e != 5'd0 && rd_e == adr && sel_e != WB_MEM)
            return 2'b01;
        else if (we_w && rd_w != 5'd0 && rd_w == adr)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign luse = hz.reg_writeE && hz.wb_selE == WB_MEM &&
                  hz.rdE != 5'd0 &&
                  (hz.rdE == hz.adr1D || hz.rdE == hz.adr2D);

    // Redirect outranks any stall; luse only matters from IDLE.
    assign redir = !rst && hz.redirectE;
    assign stall = !rst && !hz.redirectE &&
                   (state == LSTALL || luse);

    assign hz.stallF = stall;
    assign hz.stallD = stall;
    assign hz.flushD = redir;
    assign hz.flushE = stall || redir;

    assign hz.fwd_a_selD = rst ? 2'b00 :
        fwd_sel(hz.adr1D, hz.rdE, hz.reg_writeE, hz.wb_selE,
                hz.rdW, hz.reg_writeW);
    assign hz.fwd_b_selD = rst ? 2'b00 :
        fwd_sel(hz.adr2D, hz.rdE, hz.reg_writeE, hz.wb_selE,
                hz.rdW, hz.reg_writeW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (hz.redirectE) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (luse && LOAD_LAT > 1) begin
                        state <= LSTALL;
                        cnt   <= LAT_M1;
                    end
                end
                LSTALL: begin
                    if (cnt == 3'd1) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (hz.redirectE)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances
// driven with directed vectors; a negedge monitor pops expectations.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if if1 ();
    hazard_ctrl_if if3 ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    hazard_ctrl #(.LOAD_LAT(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .hz(if1.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt(sc1),
        .flush_cnt(fc1)
`endif
    );

    hazard_ctrl #(.LOAD_LAT(3)) dut3 (
        .clk(clk),
        .rst(rst),
        .hz(if3.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt(sc3),
        .flush_cnt(fc3)
`endif
    );

    typedef struct {
        string       name;
        bit          sel3;
        logic [7:0]  exp;
        bit          ck;
        logic [31:0] sc;
        logic [31:0] fc;
    } item_t;

    item_t q[$];
    int checks = 0;
    int errors = 0;

    bit          nxt_ck = 1'b0;
    logic [31:0] nxt_sc = 32'd0;
    logic [31:0] nxt_fc = 32'd0;

    task automatic drive(
        input string      name,
        input bit         s3,
        input bit         r,
        input logic [4:0] a1,
        input logic [4:0] a2,
        input logic [4:0] rde,
        input bit         rwe,
        input logic [1:0] wbe,
        input logic [4:0] rdw,
        input bit         rww,
        input bit         red,
        input bit         sf,
        input bit         fd,
        input bit         fe,
        input logic [1:0] fa,
        input logic [1:0] fb
    );
        item_t it;
        @(posedge clk);
        #1;
        rst = r;
        if1.adr1D      = s3 ? 5'd0 : a1;
        if1.adr2D      = s3 ? 5'd0 : a2;
        if1.rdE        = s3 ? 5'd0 : rde;
        if1.reg_writeE = s3 ? 1'b0 : rwe;
        if1.wb_selE    = s3 ? 2'd0 : wbe;
        if1.rdW        = s3 ? 5'd0 : rdw;
        if1.reg_writeW = s3 ? 1'b0 : rww;
        if1.redirectE  = s3 ? 1'b0 : red;
        if3.adr1D      = s3 ? a1 : 5'd0;
        if3.adr2D      = s3 ? a2 : 5'd0;
        if3.rdE        = s3 ? rde : 5'd0;
        if3.reg_writeE = s3 ? rwe : 1'b0;
        if3.wb_selE    = s3 ? wbe : 2'd0;
        if3.rdW        = s3 ? rdw : 5'd0;
        if3.reg_writeW = s3 ? rww : 1'b0;
        if3.redirectE  = s3 ? red : 1'b0;
        it.name = name;
        it.sel3 = s3;
        it.exp  = {sf, sf, fd, fe, fa, fb};
        it.ck   = nxt_ck;
        it.sc   = nxt_sc;
        it.fc   = nxt_fc;
        nxt_ck  = 1'b0;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        item_t      it;
        logic [7:0] act;
        if (q.size() > 0) begin
            it = q.pop_front();
            if (it.sel3)
                act = {if3.stallF, if3.stallD, if3.flushD, if3.flushE,
                       if3.fwd_a_selD, if3.fwd_b_selD};
            else
                act = {if1.stallF, if1.stallD, if1.flushD, if1.flushE,
                       if1.fwd_a_selD, if1.fwd_b_selD};
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: {sF,sD,fD,fE,fa,fb} got %b want %b",
                         it.name, act, it.exp);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (it.ck) begin
                checks++;
                if (sc3 !== it.sc || fc3 !== it.fc) begin
                    errors++;
                    $display("FAIL %s_cnt: stall/flush got %0d/%0d want %0d/%0d",
                             it.name, sc3, fc3, it.sc, it.fc);
                end
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //     name        s3 r  a1 a2 rdE we wb  rdW ww rd  sF fD fE fa fb
        drive("rst1",     0, 1, 5, 5, 5, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        drive("rst3",     1, 1, 5, 5, 5, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        drive("l1_luse",  0, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("l1_wbfwd", 0, 0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 2, 0);
        drive("l1_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("l3_s1",    1, 0, 0, 5, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("l3_s2",    1, 0, 0, 5, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("l3_s3",    1, 0, 0, 5, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("l3_end",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("r_s1",     1, 0, 0, 5, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("r_red",    1, 0, 0, 5, 5, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        drive("r_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("fwd_ex",   1, 0, 7, 7, 7, 1, 0, 7, 1, 0, 0, 0, 0, 1, 1);
        drive("fwd_wb",   1, 0, 7, 7, 0, 1, 0, 7, 1, 0, 0, 0, 0, 2, 2);
        drive("fwd_x0",   1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive("ld_fwd",   0, 0, 7, 8, 8, 1, 1, 7, 1, 0, 1, 0, 1, 2, 0);
        drive("ld_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("lu_red",   1, 0, 5, 0, 5, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        drive("lu_red_n", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("mr_s1",    1, 0, 5, 5, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("mr_rst",   1, 1, 5, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("mr_idle",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        drive("p_a1",     1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("p_a2",     1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("p_a3",     1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("p_gap",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("p_b1",     1, 0, 0, 6, 6, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("p_b2",     1, 0, 0, 6, 6, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("p_b3",     1, 0, 0, 6, 6, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        drive("p_red",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        nxt_ck = 1'b1; nxt_sc = 32'd6; nxt_fc = 32'd1;
        drive("p_tot",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("p_rst",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt_ck = 1'b1; nxt_sc = 32'd0; nxt_fc = 32'd0;
        drive("p_clr",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 4 && q.size() > 0; i++)
            @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
